// File: rtl/acq_scan_sequencer_if.sv
// Control/status bundle between the acquisition scan sequencer and its environment.
// master: the sequencer (drives the pulser/mux/upload controls); slave: the environment side.
interface acq_scan_sequencer_if #(
  parameter int CH_NUM = 8
);
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic              start;
  logic              stop;
  logic              cont;
  logic [CH_NUM-1:0] chan_mask;
  logic [15:0]       settle_cycles;
  logic [31:0]       prf_period;
  logic [7:0]        avg_num;
  logic              AD_sample_en;
  logic              upload_ack;
  logic [CW-1:0]     chan_sel;
  logic              pulse_trig;
  logic              burst_syn;
  logic              upload_req;
  logic [7:0]        shot_cnt;
  logic              busy;
  logic              frame_done;
  logic              timeout_err;

  modport master (
    input  start, stop, cont, chan_mask, settle_cycles, prf_period, avg_num,
           AD_sample_en, upload_ack,
    output chan_sel, pulse_trig, burst_syn, upload_req, shot_cnt, busy,
           frame_done, timeout_err
  );

  modport slave (
    output start, stop, cont, chan_mask, settle_cycles, prf_period, avg_num,
           AD_sample_en, upload_ack,
    input  chan_sel, pulse_trig, burst_syn, upload_req, shot_cnt, busy,
           frame_done, timeout_err
  );
endinterface

// File: rtl/acq_scan_sequencer.sv
// Sequences per-channel flaw-detection shots: mux select, settle, fire, capture, upload.
// Latency: first pulse_trig 1 + enabled-channel seek + max(settle_cycles,1) + 1 cycles after start.
// Backpressure: stalls in UPLOAD until upload_ack; capture length is owned by AD_sample_en.
module acq_scan_sequencer #(
  parameter int CH_NUM  = 8,
  parameter int TIMEOUT = 1024,
  parameter int PULSE_W = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  acq_scan_sequencer_if.master bus
);
  localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int PW = $clog2(PULSE_W + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(CH_NUM - 1);

  typedef enum logic [3:0] {
    IDLE, SEEK, SETTLE, WAIT_PRF, FIRE, WAIT_START, WAIT_END, UPLOAD, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     chan_sel_q, chan_sel_d;
  logic [7:0]        shot_cnt_q, shot_cnt_d;
  logic [31:0]       tmr_q, tmr_d;
  logic [31:0]       prf_cnt_q, prf_cnt_d;
  logic [PW-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic              burst_syn_q, burst_syn_d;
  logic              upload_req_q, upload_req_d;
  logic              frame_done_q, frame_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              stop_q, stop_d;
  logic              first_q, first_d;
  logic [CH_NUM-1:0] mask_q, mask_d;
  logic [15:0]       settle_q, settle_d;
  logic [31:0]       prf_q, prf_d;
  logic [7:0]        avg_q, avg_d;

  logic [16:0]       settle_eff;
  logic [8:0]        avg_eff;

  // Zero settle / zero averaging both behave as one.
  assign settle_eff = (settle_q == 16'd0) ? 17'd1 : {1'b0, settle_q};
  assign avg_eff    = (avg_q == 8'd0) ? 9'd1 : {1'b0, avg_q};

  // Next-state and output decode for the scan FSM.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    chan_sel_d    = chan_sel_q;
    shot_cnt_d    = shot_cnt_q;
    tmr_d         = tmr_q;
    burst_syn_d   = burst_syn_q;
    upload_req_d  = upload_req_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    stop_d        = stop_q;
    first_d       = first_q;
    mask_d        = mask_q;
    settle_d      = settle_q;
    prf_d         = prf_q;
    avg_d         = avg_q;
    // Pulse width runs on its own so FIRE can move on after one cycle.
    pulse_cnt_d   = (pulse_cnt_q != '0) ? pulse_cnt_q - PW'(1) : pulse_cnt_q;
    prf_cnt_d     = (prf_cnt_q == '1) ? prf_cnt_q : prf_cnt_q + 32'd1;

    if (state_q != IDLE && bus.stop) stop_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mask_d        = bus.chan_mask;
          settle_d      = bus.settle_cycles;
          prf_d         = bus.prf_period;
          avg_d         = bus.avg_num;
          timeout_err_d = 1'b0;
          stop_d        = 1'b0;
          first_d       = 1'b1;
          idx_d         = '0;
          if (bus.chan_mask == '0) frame_done_d = 1'b1;
          else                     state_d = SEEK;
        end
      end
      SEEK: begin
        if (mask_q[idx_q]) begin
          chan_sel_d = idx_q;
          shot_cnt_d = 8'd0;
          tmr_d      = 32'd0;
          state_d    = SETTLE;
        end else if (idx_q == LAST_IDX) begin
          frame_done_d = 1'b1;
          state_d      = DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      SETTLE: begin
        if (tmr_q + 32'd1 >= 32'(settle_eff)) state_d = WAIT_PRF;
        else                                   tmr_d = tmr_q + 32'd1;
      end
      WAIT_PRF: begin
        // FIRE begins the cycle after this decision, hence the +1: rises land exactly prf_period apart.
        // Only the first shot after an accepted start skips the repetition wait.
        if (first_q || (({1'b0, prf_cnt_q} + 33'd1) >= {1'b0, prf_q})) begin
          prf_cnt_d   = 32'd0;
          pulse_cnt_d = PW'(PULSE_W);
          burst_syn_d = 1'b1;
          first_d     = 1'b0;
          tmr_d       = 32'd0;
          state_d     = FIRE;
        end
      end
      FIRE: begin
        // tmr counts cycles since burst_syn rose, FIRE cycle included.
        tmr_d   = tmr_q + 32'd1;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (bus.AD_sample_en) begin
          state_d = WAIT_END;
        end else if (tmr_q >= 32'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          burst_syn_d   = 1'b0;
          pulse_cnt_d   = '0;
          state_d       = IDLE;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      WAIT_END: begin
        if (!bus.AD_sample_en) begin
          burst_syn_d  = 1'b0;
          upload_req_d = 1'b1;
          state_d      = UPLOAD;
        end
      end
      UPLOAD: begin
        if (bus.upload_ack) begin
          upload_req_d = 1'b0;
          shot_cnt_d   = shot_cnt_q + 8'd1;
          if (({1'b0, shot_cnt_q} + 9'd1) < avg_eff) begin
            state_d = WAIT_PRF;
          end else if (stop_q) begin
            state_d = IDLE;
          end else if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            idx_d   = idx_q + CW'(1);
            state_d = SEEK;
          end
        end
      end
      DONE: begin
        if (bus.cont && !stop_q) begin
          idx_d   = '0;
          state_d = SEEK;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      chan_sel_q    <= '0;
      shot_cnt_q    <= '0;
      tmr_q         <= '0;
      prf_cnt_q     <= '0;
      pulse_cnt_q   <= '0;
      burst_syn_q   <= 1'b0;
      upload_req_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      stop_q        <= 1'b0;
      first_q       <= 1'b0;
      mask_q        <= '0;
      settle_q      <= '0;
      prf_q         <= '0;
      avg_q         <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      chan_sel_q    <= chan_sel_d;
      shot_cnt_q    <= shot_cnt_d;
      tmr_q         <= tmr_d;
      prf_cnt_q     <= prf_cnt_d;
      pulse_cnt_q   <= pulse_cnt_d;
      burst_syn_q   <= burst_syn_d;
      upload_req_q  <= upload_req_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      stop_q        <= stop_d;
      first_q       <= first_d;
      mask_q        <= mask_d;
      settle_q      <= settle_d;
      prf_q         <= prf_d;
      avg_q         <= avg_d;
    end
  end

  assign bus.chan_sel    = chan_sel_q;
  assign bus.pulse_trig  = (pulse_cnt_q != '0);
  assign bus.burst_syn   = burst_syn_q;
  assign bus.upload_req  = upload_req_q;
  assign bus.shot_cnt    = shot_cnt_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_done  = frame_done_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_acq_scan_sequencer.sv
// Bench for acq_scan_sequencer: AD/upload responders, shot monitor and frame-level scoreboard.
// Inputs driven 1 time unit after posedge (main) or at negedge (responders); outputs sampled off-edge.
// Responders honour burst_syn/upload_req handshakes with programmable delays.
module tb_acq_scan_sequencer;
  localparam int CH_NUM  = 8;
  localparam int TIMEOUT = 1024;
  localparam int PULSE_W = 10;

  logic clk;
  logic reset;

  acq_scan_sequencer_if #(.CH_NUM(CH_NUM)) bus ();

  acq_scan_sequencer #(.CH_NUM(CH_NUM), .TIMEOUT(TIMEOUT), .PULSE_W(PULSE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment knobs set by the main sequence, read by the responders/monitor.
  int cur_prf = 0, cur_avg_eff = 1, ad_delay = 3, ad_hold = 10, ack_delay = 0;
  bit ack_hold = 0, ad_never = 0;

  // Monitor results.
  int cyc = 0, fd_count = 0, upload_count = 0, last_bs_run = 0;
  int fire_t[$];
  int fire_ch[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor plus AD sample-enable and upload responders.
  initial begin : monitor
    bit pt, bs, ur, fd, ack_now;
    bit pt_prev, bs_prev, ur_prev, have_prev, rep_pending, bs_low_seen;
    int pw_run, bs_run, ur_run, rep_count, accept_cyc, ack_cnt, ad_ph, ad_cnt, exp_t;
    pt_prev = 0; bs_prev = 0; ur_prev = 0; have_prev = 0; rep_pending = 0; bs_low_seen = 1;
    pw_run = 0; bs_run = 0; ur_run = 0; rep_count = 0; accept_cyc = 0; ack_cnt = 0;
    ad_ph = 0; ad_cnt = 0;
    bus.AD_sample_en = 1'b0;
    bus.upload_ack   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      pt = bus.pulse_trig; bs = bus.burst_syn; ur = bus.upload_req; fd = bus.frame_done;
      if (reset) begin
        pt = 0; bs = 0; ur = 0;
        pw_run = 0; bs_run = 0; ur_run = 0; rep_pending = 0; rep_count = 0;
        have_prev = 0; bs_low_seen = 1; ad_ph = 0; ad_cnt = 0; ack_cnt = 0;
        bus.AD_sample_en = 1'b0;
        bus.upload_ack   = 1'b0;
      end else begin
        if (bus.start) begin
          have_prev = 0; rep_pending = 0; rep_count = 0;
        end
        if (pt && !pt_prev) begin
          check_eq("burst_with_fire", bs, 1);
          check_eq("burst_gap_before_fire", bs_low_seen, 1);
          if (rep_pending) begin
            exp_t = (fire_t[$] + cur_prf > accept_cyc + 2) ? fire_t[$] + cur_prf : accept_cyc + 2;
            check_eq("fire_time", cyc, exp_t);
          end else if (have_prev) begin
            check_eq("prf_min_spacing", (cyc - fire_t[$]) >= cur_prf, 1);
          end
          fire_t.push_back(cyc);
          fire_ch.push_back(int'(bus.chan_sel));
          have_prev = 1; rep_pending = 0; bs_low_seen = 0; pw_run = 0;
        end
        if (pt) pw_run++;
        if (!pt && pt_prev) check_eq("pulse_width", pw_run, PULSE_W);
        if (!bs) bs_low_seen = 1;
        if (bs) bs_run++;
        else begin
          if (bs_prev) last_bs_run = bs_run;
          bs_run = 0;
        end
        if (ur) begin
          ur_run++;
          if (!ur_prev) upload_count++;
        end else begin
          if (ur_prev) check_eq("upload_req_width", ur_run, ack_hold ? 1 : ack_delay + 1);
          ur_run = 0;
        end
        if (fd) fd_count++;

        ack_now = 0;
        if (ack_hold) ack_now = 1;
        else if (ur) begin
          if (ack_cnt == ack_delay) ack_now = 1;
          ack_cnt++;
        end else ack_cnt = 0;
        bus.upload_ack = ack_now;
        if (ur && ack_now) begin
          rep_count++;
          if (rep_count < cur_avg_eff) begin
            rep_pending = 1;
            accept_cyc  = cyc;
          end else begin
            rep_count = 0; rep_pending = 0;
          end
        end

        case (ad_ph)
          0: if (bs && !ad_never) begin ad_ph = 1; ad_cnt = 0; end
          1: begin
            ad_cnt++;
            if (ad_cnt >= ad_delay) begin bus.AD_sample_en = 1'b1; ad_ph = 2; ad_cnt = 0; end
          end
          2: begin
            ad_cnt++;
            if (ad_cnt >= ad_hold) begin bus.AD_sample_en = 1'b0; ad_ph = 3; end
          end
          default: if (!bs) ad_ph = 0;
        endcase
      end
      pt_prev = pt; bs_prev = bs; ur_prev = ur;
    end
  end

  task automatic start_cfg(input logic [7:0] mask, input int avg, input int settle,
                           input int prf, input bit cont);
    cur_prf           = prf;
    cur_avg_eff       = (avg == 0) ? 1 : avg;
    bus.chan_mask     = mask;
    bus.avg_num       = 8'(avg);
    bus.settle_cycles = 16'(settle);
    bus.prf_period    = 32'(prf);
    bus.cont          = cont;
    bus.start         = 1'b1;
    tick();
    bus.start         = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      tick();
      n++;
    end
    check_eq("idle_within_budget", bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_chan_sel"}, bus.chan_sel, 0);
    check_eq({tag, "_pulse_trig"}, bus.pulse_trig, 0);
    check_eq({tag, "_burst_syn"}, bus.burst_syn, 0);
    check_eq({tag, "_upload_req"}, bus.upload_req, 0);
    check_eq({tag, "_shot_cnt"}, bus.shot_cnt, 0);
    check_eq({tag, "_busy"}, bus.busy, 0);
    check_eq({tag, "_frame_done"}, bus.frame_done, 0);
    check_eq({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  // One non-continuous frame scored against the expected shot list.
  task automatic run_frame(input logic [7:0] mask, input int avg, input int settle, input int prf);
    int exp_ch[$];
    int b_f, b_u, b_d, aeff;
    aeff = (avg == 0) ? 1 : avg;
    for (int c = 0; c < CH_NUM; c++)
      if (mask[c]) for (int k = 0; k < aeff; k++) exp_ch.push_back(c);
    b_f = fire_t.size(); b_u = upload_count; b_d = fd_count;
    start_cfg(mask, avg, settle, prf, 1'b0);
    // Configuration is latched at start; later changes must be ignored.
    bus.chan_mask     = 8'($urandom);
    bus.avg_num       = 8'($urandom);
    bus.settle_cycles = 16'($urandom_range(0, 50));
    bus.prf_period    = 32'($urandom_range(0, 300));
    wait_idle(40000);
    tick();
    check_eq("shot_count", fire_t.size() - b_f, exp_ch.size());
    check_eq("upload_count", upload_count - b_u, exp_ch.size());
    check_eq("frame_done_count", fd_count - b_d, 1);
    check_eq("final_shot_cnt", bus.shot_cnt, aeff);
    check_eq("no_timeout", bus.timeout_err, 0);
    for (int i = 0; i < exp_ch.size() && (b_f + i) < fire_t.size(); i++)
      check_eq("chan_seq", fire_ch[b_f + i], exp_ch[i]);
  endtask

  initial begin : main
    int b_f, b_u, b_d, n, d_at_stop, f_at;
    reset = 1'b1;
    bus.start = 0; bus.stop = 0; bus.cont = 0; bus.chan_mask = 0;
    bus.settle_cycles = 0; bus.prf_period = 0; bus.avg_num = 0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Two channels, two shots each, exact repetition period.
    ad_delay = 3; ad_hold = 50; ack_delay = 2; ack_hold = 0;
    b_f = fire_t.size();
    run_frame(8'h05, 2, 4, 200);
    for (int i = b_f + 1; i < fire_t.size(); i++)
      check_eq("prf_exact_200", fire_t[i] - fire_t[i-1], 200);

    // Empty mask: frame_done one cycle after start, never busy.
    b_d = fd_count;
    start_cfg(8'h00, 1, 0, 0, 1'b0);
    check_eq("mask0_frame_done", bus.frame_done, 1);
    check_eq("mask0_busy", bus.busy, 0);
    tick();
    check_eq("mask0_frame_done_drop", bus.frame_done, 0);
    check_eq("mask0_busy_after", bus.busy, 0);
    check_eq("mask0_pulse_trig", bus.pulse_trig, 0);
    check_eq("mask0_burst_syn", bus.burst_syn, 0);
    check_eq("mask0_fd_pulses", fd_count - b_d, 1);

    // AD never responds: burst_syn held TIMEOUT cycles, sticky error, next start clears it.
    ad_never = 1;
    b_d = fd_count; b_u = upload_count;
    start_cfg(8'h10, 1, 0, 0, 1'b0);
    wait_idle(3000);
    tick();
    check_eq("timeout_err_set", bus.timeout_err, 1);
    check_eq("timeout_burst_len", last_bs_run, TIMEOUT);
    check_eq("timeout_burst_low", bus.burst_syn, 0);
    check_eq("timeout_pulse_low", bus.pulse_trig, 0);
    check_eq("timeout_no_frame_done", fd_count - b_d, 0);
    check_eq("timeout_no_upload", upload_count - b_u, 0);
    ad_never = 0;
    start_cfg(8'h01, 1, 0, 0, 1'b0);
    check_eq("timeout_err_cleared", bus.timeout_err, 0);
    wait_idle(3000);

    // Continuous scan of channel 7, then stop during a capture.
    ad_delay = 2; ad_hold = 10; ack_delay = 1; ack_hold = 0;
    b_d = fd_count; b_f = fire_t.size(); b_u = upload_count;
    start_cfg(8'h80, 1, 1, 50, 1'b1);
    n = 0;
    while ((fd_count - b_d) < 3 && n < 5000) begin tick(); n++; end
    check_eq("cont_frames", (fd_count - b_d) >= 3, 1);
    n = 0;
    while (!bus.AD_sample_en && n < 500) begin tick(); n++; end
    check_eq("cont_capture_seen", bus.AD_sample_en, 1);
    d_at_stop = fd_count;
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    wait_idle(2000);
    bus.cont = 1'b0;
    tick();
    check_eq("stop_no_frame_done", fd_count, d_at_stop);
    check_eq("stop_uploads_complete", upload_count - b_u, fire_t.size() - b_f);
    f_at = fire_t.size();
    repeat (300) tick();
    check_eq("stop_no_more_fire", fire_t.size(), f_at);
    for (int i = b_f; i < fire_t.size(); i++) check_eq("cont_chan_7", fire_ch[i], 7);

    // Short PRF with long capture, ack already high: fire right after WAIT_PRF, 1-cycle upload_req.
    ad_delay = 2; ad_hold = 20; ack_hold = 1;
    run_frame(8'h03, 3, 1, 5);
    ack_hold = 0;

    // Reset during WAIT_END, then a clean frame.
    ad_delay = 3; ad_hold = 60; ack_delay = 1;
    start_cfg(8'h02, 1, 2, 100, 1'b0);
    n = 0;
    while (!bus.AD_sample_en && n < 500) begin tick(); n++; end
    check_eq("capture_before_reset", bus.AD_sample_en, 1);
    tick();
    reset = 1'b1;
    tick();
    check_all_zero("midrst");
    reset = 1'b0;
    tick();
    run_frame(8'h02, 1, 2, 100);

    // Randomized frames.
    for (int it = 0; it < 5; it++) begin
      ad_delay  = $urandom_range(1, 5);
      ad_hold   = $urandom_range(1, 30);
      ack_hold  = ($urandom_range(0, 3) == 0);
      ack_delay = $urandom_range(0, 3);
      run_frame(8'($urandom_range(1, 255)), $urandom_range(0, 2),
                $urandom_range(0, 6), $urandom_range(0, 120));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
